// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS multi-cycle control definitions: opcodes, ALUOp codes, mux encodings, FSM states.
// MC_JUMP_SUPPORT_EN adds the JMP state for opcode 2; otherwise opcode 2 decodes as illegal.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        StRst    = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StRex    = 4'd7,
        StRwb    = 4'd8,
        StBeq    = 4'd9,
        StIex    = 4'd10,
        StIwb    = 4'd11
`ifdef MC_JUMP_SUPPORT_EN
        , StJmp  = 4'd12
`endif
    } mc_state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

    // Successor of DECODE; StFetch marks an unsupported opcode.
    function automatic mc_state_e decode_next(input logic [5:0] opcode);
        mc_state_e nxt;
        case (opcode)
            OP_RTYPE:                          nxt = StRex;
            OP_LW, OP_SW:                      nxt = StMemAdr;
            OP_BEQ:                            nxt = StBeq;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = StIex;
`ifdef MC_JUMP_SUPPORT_EN
            OP_J:                              nxt = StJmp;
`endif
            default:                           nxt = StFetch;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control bus between the main control FSM (master) and the datapath/IR/memory side (slave).
interface mc_main_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic       IllegalOp;
    logic       MemTimeout;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, MemTimeout
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, MemTimeout
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> control-word decode for the multi-cycle controller.
// MC_JUMP_SUPPORT_EN enables the JMP control word.
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  mc_state_e state,
    output ctrl_t     ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            StDecode: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            StMemAdr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            StRex: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            StRwb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            StBeq: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            StIex: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
            end
            StIwb: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef MC_JUMP_SUPPORT_EN
            StJmp: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM with memory-ready stall and per-access wait timeout.
// MC_JUMP_SUPPORT_EN adds the jump state for opcode 2.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MAX_MEM_WAIT = 16,
    parameter int unsigned WAIT_W       = 5
) (
    input logic               clk,
    input logic               reset,
    mc_main_control_if.master bus
);

    mc_state_e   state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic        timeout_q, timeout_d;
    logic        mem_wait;
    logic        expire;
    ctrl_t       ctrl;

    always_comb begin
        state_d  = state_q;
        mem_wait = 1'b0;
        case (state_q)
            StRst:    state_d = StFetch;
            StFetch: begin
                mem_wait = 1'b1;
                if (bus.MemReady) state_d = StDecode;
            end
            StDecode: state_d = decode_next(bus.Opcode);
            StMemAdr: state_d = (bus.Opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd: begin
                mem_wait = 1'b1;
                if (bus.MemReady) state_d = StMemWb;
            end
            StMemWr: begin
                mem_wait = 1'b1;
                if (bus.MemReady) state_d = StFetch;
            end
            StRex:    state_d = StRwb;
            StIex:    state_d = StIwb;
            default:  state_d = StFetch;
        endcase

        // MemReady on the last allowed cycle takes the normal path
        expire = mem_wait && !bus.MemReady && (wait_q == WAIT_W'(MAX_MEM_WAIT - 1));
        if (expire) state_d = StFetch;

        if (state_d != state_q || expire) begin
            wait_d = '0;
        end else if (mem_wait && !bus.MemReady) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
        timeout_d = timeout_q | expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRst;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    logic fetch_hold;
    assign fetch_hold = (state_q == StFetch) && !bus.MemReady;

    assign bus.PCWrite     = ctrl.pc_write & ~fetch_hold;
    assign bus.IRWrite     = ctrl.ir_write & ~fetch_hold;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.IllegalOp   = (state_q == StDecode) && (decode_next(bus.Opcode) == StFetch);
    assign bus.MemTimeout  = timeout_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control; expected state/control words are queued per cycle and
// compared at the falling edge. Honours MC_JUMP_SUPPORT_EN for the opcode-2 case.
module tb_mc_main_control;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mc_main_control_if bus ();

    mc_main_control #(
        .MAX_MEM_WAIT (16),
        .WAIT_W       (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA},
    // ALUSrcB, PCSource, ALUOp, IllegalOp, MemTimeout
    localparam logic [17:0] W_RST   = 18'b0;
    localparam logic [17:0] W_FWAIT = {10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_FGO   = {10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_DEC   = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_MADR  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_MRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_MWB   = {10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_MWR   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_REX   = {10'b0000000001, 2'b00, 2'b00, 2'b10, 2'b00};
    localparam logic [17:0] W_RWB   = {10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_BEQ   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [17:0] W_IEX   = {10'b0000000001, 2'b10, 2'b00, 2'b11, 2'b00};
    localparam logic [17:0] W_IWB   = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] W_JMP   = {10'b1000000000, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [17:0] F_ILL   = 18'b10;
    localparam logic [17:0] F_TO    = 18'b01;

    logic [21:0] exp_q[$];

    function automatic logic [21:0] observe();
        return {4'(dut.state_q), bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.IllegalOp, bus.MemTimeout};
    endfunction

    // Queue the expectation for the current cycle, compare at negedge, advance past next posedge.
    task automatic step(input logic [3:0] st, input logic [17:0] w, input string tag);
        logic [21:0] obs;
        logic [21:0] exp;
        exp_q.push_back({st, w});
        @(negedge clk);
        obs = observe();
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                   tag, obs[21:18], obs[17:0], exp[21:18], exp[17:0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.Opcode   = 6'd35;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        @(posedge clk);
        #1;
        step(4'd0, W_RST, "rst_hold");
        reset = 1'b0;
        step(4'd0, W_RST, "rst_exit");

        // lw, no stalls: 5 cycles
        step(4'd1, W_FGO,  "lw_fetch");
        step(4'd2, W_DEC,  "lw_decode");
        step(4'd3, W_MADR, "lw_memadr");
        step(4'd4, W_MRD,  "lw_memrd");
        step(4'd5, W_MWB,  "lw_memwb");

        bus.Opcode = 6'd0;
        step(4'd1, W_FGO,  "r_fetch");
        step(4'd2, W_DEC,  "r_decode");
        step(4'd7, W_REX,  "r_rex");
        step(4'd8, W_RWB,  "r_rwb");

        bus.Opcode = 6'd4;
        bus.Zero   = 1'b1;
        step(4'd1, W_FGO,  "beq_fetch");
        step(4'd2, W_DEC,  "beq_decode");
        step(4'd9, W_BEQ,  "beq_exec");
        bus.Zero   = 1'b0;

        bus.Opcode = 6'd8;
        step(4'd1,  W_FGO, "addi_fetch");
        step(4'd2,  W_DEC, "addi_decode");
        step(4'd10, W_IEX, "addi_iex");
        step(4'd11, W_IWB, "addi_iwb");

        // sw with 4 stall cycles in MEMWR
        bus.Opcode = 6'd43;
        step(4'd1, W_FGO,  "sw_fetch");
        step(4'd2, W_DEC,  "sw_decode");
        step(4'd3, W_MADR, "sw_memadr");
        bus.MemReady = 1'b0;
        for (int i = 0; i < 4; i++) step(4'd6, W_MWR, "sw_memwr_wait");
        bus.MemReady = 1'b1;
        step(4'd6, W_MWR, "sw_memwr_done");

        bus.Opcode = 6'd2;
        step(4'd1, W_FGO, "j_fetch");
`ifdef MC_JUMP_SUPPORT_EN
        step(4'd2,  W_DEC, "j_decode");
        step(4'd12, W_JMP, "j_jmp");
`else
        step(4'd2, W_DEC | F_ILL, "j_illegal");
`endif

        bus.Opcode = 6'd63;
        step(4'd1, W_FGO,         "ill_fetch");
        step(4'd2, W_DEC | F_ILL, "ill_decode");

        // lw: ready arrives on the last allowed MEMRD cycle
        bus.Opcode = 6'd35;
        step(4'd1, W_FGO,  "lwlate_fetch");
        step(4'd2, W_DEC,  "lwlate_decode");
        step(4'd3, W_MADR, "lwlate_memadr");
        bus.MemReady = 1'b0;
        for (int i = 0; i < 15; i++) step(4'd4, W_MRD, "lwlate_memrd_wait");
        bus.MemReady = 1'b1;
        step(4'd4, W_MRD, "lwlate_memrd_last");
        step(4'd5, W_MWB, "lwlate_memwb");

        // reset held 3 cycles mid-MEMRD
        step(4'd1, W_FGO,  "lwrst_fetch");
        step(4'd2, W_DEC,  "lwrst_decode");
        step(4'd3, W_MADR, "lwrst_memadr");
        bus.MemReady = 1'b0;
        step(4'd4, W_MRD,  "lwrst_memrd");
        reset        = 1'b1;
        bus.MemReady = 1'b1;
        step(4'd4, W_MRD,  "lwrst_memrd_rstin");
        step(4'd0, W_RST,  "lwrst_rst1");
        step(4'd0, W_RST,  "lwrst_rst2");
        reset = 1'b0;
        step(4'd0, W_RST,  "lwrst_rst3");

        // FETCH timeout after 16 cycles without MemReady
        bus.MemReady = 1'b0;
        for (int i = 0; i < 16; i++) step(4'd1, W_FWAIT, "to_fetch_wait");
        step(4'd1, W_FWAIT | F_TO, "to_fetch_after");
        step(4'd1, W_FWAIT | F_TO, "to_sticky_wait");
        bus.MemReady = 1'b1;
        step(4'd1, W_FGO | F_TO,   "to_sticky_fetch");
        reset = 1'b1;
        step(4'd2, W_DEC | F_TO,   "to_sticky_decode");
        reset = 1'b0;
        step(4'd0, W_RST,          "to_cleared");
        step(4'd1, W_FGO,          "post_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish before 200000");
        $fatal(1);
    end

endmodule
